// File: rtl/fwd_pkg.sv
// Shared constants, stage-record control fields and select helper for the forwarding/hazard unit.
// Optional statistics counters are enabled with the FWD_HAZARD_STATS_EN macro (see fwd_hazard_ctrl).
package fwd_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned SEL_W      = 2;

  localparam logic [SEL_W-1:0] SEL_REG = 2'b00;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'b01;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_IMM = 2'b11;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic alusrc;
  } stage_ctl_t;

  localparam stage_ctl_t BUBBLE = '0;

  // MEM wins over WB; register 0 never forwards.
  function automatic logic [SEL_W-1:0] sel_from_hits(input logic src_nz,
                                                     input logic mem_hit,
                                                     input logic wb_hit);
    logic [SEL_W-1:0] sel;
    sel = SEL_REG;
    if (src_nz && mem_hit) begin
      sel = SEL_MEM;
    end else if (src_nz && wb_hit) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request bundle and mux-select / stall response of the forwarding unit.
interface fwd_hazard_ctrl_if
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) ();

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              id_alusrc_i;
  logic              flush_i;
  logic [SEL_W-1:0]  fwd_a_sel_o;
  logic [SEL_W-1:0]  fwd_b_sel_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  fwd_cnt_o;

  // Decode side: presents the ID instruction, consumes selects and stall.
  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_rd_i,
           id_regwrite_i, id_memread_i, id_alusrc_i, flush_i,
    input  fwd_a_sel_o, fwd_b_sel_o, stall_o, stall_cnt_o, fwd_cnt_o
  );

  // Forwarding unit side.
  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_rd_i,
           id_regwrite_i, id_memread_i, id_alusrc_i, flush_i,
    output fwd_a_sel_o, fwd_b_sel_o, stall_o, stall_cnt_o, fwd_cnt_o
  );

endinterface

// File: rtl/fwd_stage_reg.sv
// One pipeline stage record of register ownership; reset or bubble-insert loads an empty slot.
module fwd_stage_reg
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_bubble,
  input  stage_ctl_t        i_ctl,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic [REG_AW-1:0] i_rd,
  output stage_ctl_t        o_ctl,
  output logic [REG_AW-1:0] o_rs,
  output logic [REG_AW-1:0] o_rt,
  output logic [REG_AW-1:0] o_rd
);

  stage_ctl_t        r_ctl;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;

  // Capture the upstream record, or an empty one on reset/bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i || i_bubble) begin
      r_ctl <= BUBBLE;
      r_rs  <= '0;
      r_rt  <= '0;
      r_rd  <= '0;
    end else begin
      r_ctl <= i_ctl;
      r_rs  <= i_rs;
      r_rt  <= i_rt;
      r_rd  <= i_rd;
    end
  end

  assign o_ctl = r_ctl;
  assign o_rs  = r_rs;
  assign o_rt  = r_rt;
  assign o_rd  = r_rd;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects and load-use stall generation.
// Define FWD_HAZARD_STATS_EN to build saturating stall/forward event counters;
// otherwise the counter outputs are tied to zero.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input logic               clk_i,
  input logic               rst_i,
  fwd_hazard_ctrl_if.slave  bus
);

  stage_ctl_t        w_id_ctl, w_ex_ctl, w_mem_ctl, w_wb_ctl;
  logic [REG_AW-1:0] w_ex_rs, w_ex_rt, w_ex_rd;
  logic [REG_AW-1:0] w_mem_rs, w_mem_rt, w_mem_rd;
  logic [REG_AW-1:0] w_wb_rs, w_wb_rt, w_wb_rd;
  logic              w_stall, w_load_ex;
  logic              w_mem_hit_a, w_mem_hit_b, w_wb_hit_a, w_wb_hit_b;
  logic [SEL_W-1:0]  w_a_sel, w_b_sel;
  logic              w_unused;

  // Pack the ID control bits into a stage record.
  always_comb begin
    w_id_ctl          = BUBBLE;
    w_id_ctl.valid    = bus.id_valid_i;
    w_id_ctl.regwrite = bus.id_regwrite_i;
    w_id_ctl.memread  = bus.id_memread_i;
    w_id_ctl.alusrc   = bus.id_alusrc_i;
  end

  // Load-use hazard: a load in EX feeds a register the ID instruction reads; a flush cancels it.
  always_comb begin
    w_stall = w_ex_ctl.valid && w_ex_ctl.memread && (w_ex_rd != '0) && bus.id_valid_i &&
              !bus.flush_i &&
              ((w_ex_rd == bus.id_rs_i) || ((w_ex_rd == bus.id_rt_i) && !bus.id_alusrc_i));
  end

  assign w_load_ex = bus.id_valid_i && !w_stall && !bus.flush_i;

  fwd_stage_reg #(.REG_AW(REG_AW)) u_ex (
    .clk_i (clk_i), .rst_i (rst_i), .i_bubble (!w_load_ex),
    .i_ctl (w_id_ctl), .i_rs (bus.id_rs_i), .i_rt (bus.id_rt_i), .i_rd (bus.id_rd_i),
    .o_ctl (w_ex_ctl), .o_rs (w_ex_rs), .o_rt (w_ex_rt), .o_rd (w_ex_rd)
  );

  fwd_stage_reg #(.REG_AW(REG_AW)) u_mem (
    .clk_i (clk_i), .rst_i (rst_i), .i_bubble (1'b0),
    .i_ctl (w_ex_ctl), .i_rs (w_ex_rs), .i_rt (w_ex_rt), .i_rd (w_ex_rd),
    .o_ctl (w_mem_ctl), .o_rs (w_mem_rs), .o_rt (w_mem_rt), .o_rd (w_mem_rd)
  );

  fwd_stage_reg #(.REG_AW(REG_AW)) u_wb (
    .clk_i (clk_i), .rst_i (rst_i), .i_bubble (1'b0),
    .i_ctl (w_mem_ctl), .i_rs (w_mem_rs), .i_rt (w_mem_rt), .i_rd (w_mem_rd),
    .o_ctl (w_wb_ctl), .o_rs (w_wb_rs), .o_rt (w_wb_rt), .o_rd (w_wb_rd)
  );

  // Ownership match of EX sources against the MEM and WB writers.
  always_comb begin
    w_mem_hit_a = w_mem_ctl.valid && w_mem_ctl.regwrite && (w_mem_rd == w_ex_rs);
    w_mem_hit_b = w_mem_ctl.valid && w_mem_ctl.regwrite && (w_mem_rd == w_ex_rt);
    w_wb_hit_a  = w_wb_ctl.valid && w_wb_ctl.regwrite && (w_wb_rd == w_ex_rs);
    w_wb_hit_b  = w_wb_ctl.valid && w_wb_ctl.regwrite && (w_wb_rd == w_ex_rt);
  end

  // Operand mux selects; B takes the immediate when the EX instruction uses one.
  always_comb begin
    w_a_sel = sel_from_hits(w_ex_rs != '0, w_mem_hit_a, w_wb_hit_a);
    w_b_sel = SEL_REG;
    if (w_ex_ctl.alusrc) begin
      w_b_sel = SEL_IMM;
    end else begin
      w_b_sel = sel_from_hits(w_ex_rt != '0, w_mem_hit_b, w_wb_hit_b);
    end
  end

  assign bus.fwd_a_sel_o = rst_i ? SEL_REG : w_a_sel;
  assign bus.fwd_b_sel_o = rst_i ? SEL_REG : w_b_sel;
  assign bus.stall_o     = !rst_i && w_stall;

`ifdef FWD_HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt, r_fwd_cnt;
  logic             w_fwd_evt;

  assign w_fwd_evt = (bus.fwd_a_sel_o == SEL_MEM) || (bus.fwd_a_sel_o == SEL_WB) ||
                     (bus.fwd_b_sel_o == SEL_MEM) || (bus.fwd_b_sel_o == SEL_WB);

  // Saturating event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (bus.stall_o && !bus.flush_i && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_fwd_evt && (r_fwd_cnt != '1)) begin
        r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt_o = rst_i ? {CNT_W{1'b0}} : r_stall_cnt;
  assign bus.fwd_cnt_o   = rst_i ? {CNT_W{1'b0}} : r_fwd_cnt;
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
  assign bus.fwd_cnt_o   = {CNT_W{1'b0}};
`endif

  // WB fields past the last consumer are intentionally left dangling.
  assign w_unused = &{1'b0, w_wb_rs, w_wb_rt, w_wb_ctl.memread, w_wb_ctl.alusrc};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios plus random traffic against an
// instruction-history reference model. Honours FWD_HAZARD_STATS_EN like the design.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    bit v;
    int rs;
    int rt;
    int rd;
    bit rw;
    bit mr;
    bit as;
  } ins_t;

  // hist[0] = instruction now in EX, hist[1] = one cycle older (MEM), hist[2] = WB.
  ins_t hist[$];
  ins_t cur;
  bit   cur_flush, cur_rst;
  bit   exp_stall;
  int   exp_a, exp_b;
  int   exp_scnt, exp_fcnt;
  int   checks, errors;
  localparam int CMAX = 65535;

  function automatic ins_t empty_ins();
    ins_t b;
    b = '{v: 0, rs: 0, rt: 0, rd: 0, rw: 0, mr: 0, as: 0};
    return b;
  endfunction

  // Most recent older writer of src wins; r0 and empty slots never supply data.
  function automatic int sel_for(int src);
    if (src == 0) return 0;
    if (hist[1].v && hist[1].rw && hist[1].rd == src) return 1;
    if (hist[2].v && hist[2].rw && hist[2].rd == src) return 2;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Present one ID instruction for this cycle and compare all outputs with the model.
  task automatic set_in(input bit v, input int rs, input int rt, input int rd,
                        input bit rw, input bit mr, input bit as, input bit fl, input bit r);
    ins_t ex, mm;
    cur = '{v: v, rs: rs, rt: rt, rd: rd, rw: rw, mr: mr, as: as};
    cur_flush = fl;
    cur_rst   = r;
    rst = r;
    bus.id_valid_i    = v;
    bus.id_rs_i       = 5'(rs);
    bus.id_rt_i       = 5'(rt);
    bus.id_rd_i       = 5'(rd);
    bus.id_regwrite_i = rw;
    bus.id_memread_i  = mr;
    bus.id_alusrc_i   = as;
    bus.flush_i       = fl;
    #1;
    ex = hist[0];
    mm = hist[1];
    exp_stall = !r && v && !fl && ex.v && ex.mr && ex.rd != 0 &&
                (ex.rd == rs || (ex.rd == rt && !as));
    exp_a = (r || !ex.v) ? 0 : sel_for(ex.rs);
    exp_b = (r || !ex.v) ? 0 : (ex.as ? 3 : sel_for(ex.rt));
    assert (!(ex.v && mm.v && mm.mr && mm.rd != 0 &&
              (mm.rd == ex.rs || (mm.rd == ex.rt && !ex.as)))) else begin
      errors++;
      $error("FAIL load_in_mem_feeds_ex rd=%0d", mm.rd);
    end
    chk("sel_a", bus.fwd_a_sel_o, 32'(exp_a));
    chk("sel_b", bus.fwd_b_sel_o, 32'(exp_b));
    chk("stall", bus.stall_o, 32'(exp_stall));
`ifdef FWD_HAZARD_STATS_EN
    chk("stall_cnt", bus.stall_cnt_o, r ? 32'd0 : 32'(exp_scnt));
    chk("fwd_cnt", bus.fwd_cnt_o, r ? 32'd0 : 32'(exp_fcnt));
`else
    chk("stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("fwd_cnt", bus.fwd_cnt_o, 32'd0);
`endif
  endtask

  // Advance one clock and age the model history.
  task automatic tick();
    ins_t nx;
    @(posedge clk);
    if (cur_rst) begin
      hist.delete();
      repeat (3) hist.push_back(empty_ins());
      exp_scnt = 0;
      exp_fcnt = 0;
    end else begin
      if (exp_stall && exp_scnt < CMAX) exp_scnt++;
      if ((exp_a == 1 || exp_a == 2 || exp_b == 1 || exp_b == 2) && exp_fcnt < CMAX) exp_fcnt++;
      nx = (cur.v && !exp_stall && !cur_flush) ? cur : empty_ins();
      hist.push_front(nx);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic nop();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    ins_t h;
    bit   hold;
    checks = 0;
    errors = 0;
    exp_scnt = 0;
    exp_fcnt = 0;
    repeat (3) hist.push_back(empty_ins());

    // Reset
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    set_in(1, 1, 2, 3, 1, 0, 0, 0, 1); tick();
    nop();
    chk("rst_a", bus.fwd_a_sel_o, 32'd0);
    chk("rst_stall", bus.stall_o, 32'd0);
    tick();

    // ADD r3 ; SUB r4,r3,r2
    set_in(1, 1, 2, 3, 1, 0, 0, 0, 0); tick();
    set_in(1, 3, 2, 4, 1, 0, 0, 0, 0); tick();
    nop();
    chk("t1_a", bus.fwd_a_sel_o, 32'd1);
    chk("t1_b", bus.fwd_b_sel_o, 32'd0);
    tick();

    // ADD r3 ; NOP ; SUB r4,r3,r3
    set_in(1, 1, 2, 3, 1, 0, 0, 0, 0); tick();
    nop(); tick();
    set_in(1, 3, 3, 4, 1, 0, 0, 0, 0); tick();
    nop();
    chk("t2_wb_a", bus.fwd_a_sel_o, 32'd2);
    chk("t2_wb_b", bus.fwd_b_sel_o, 32'd2);
    tick();

    // ADD r3 ; ADD r3 ; SUB ..r3 -> MEM priority
    set_in(1, 1, 2, 3, 1, 0, 0, 0, 0); tick();
    set_in(1, 2, 1, 3, 1, 0, 0, 0, 0); tick();
    set_in(1, 3, 3, 4, 1, 0, 0, 0, 0); tick();
    nop();
    chk("t2_pri_a", bus.fwd_a_sel_o, 32'd1);
    chk("t2_pri_b", bus.fwd_b_sel_o, 32'd1);
    tick();

    // LW r5 ; ADD r6,r5,r1 -> one stall cycle
    set_in(1, 1, 0, 5, 1, 1, 1, 0, 0); tick();
    set_in(1, 5, 1, 6, 1, 0, 0, 0, 0);
    chk("t3_stall", bus.stall_o, 32'd1);
    tick();
    set_in(1, 5, 1, 6, 1, 0, 0, 0, 0);
    chk("t3_stall_once", bus.stall_o, 32'd0);
    chk("t3_bubble_a", bus.fwd_a_sel_o, 32'd0);
    tick();
    nop();
    chk("t3_a", bus.fwd_a_sel_o, 32'd2);
    chk("t3_b", bus.fwd_b_sel_o, 32'd0);
    tick();

    // ADDI r0 ; ADD r7,r0,r0
    set_in(1, 1, 0, 0, 1, 0, 1, 0, 0); tick();
    set_in(1, 0, 0, 7, 1, 0, 0, 0, 0); tick();
    nop();
    chk("t4_r0_a", bus.fwd_a_sel_o, 32'd0);
    chk("t4_r0_b", bus.fwd_b_sel_o, 32'd0);
    tick();

    // ADD r2 ; ADDI r8,r2,imm
    set_in(1, 1, 1, 2, 1, 0, 0, 0, 0); tick();
    set_in(1, 2, 2, 8, 1, 0, 1, 0, 0); tick();
    nop();
    chk("t4_imm_b", bus.fwd_b_sel_o, 32'd3);
    chk("t4_imm_a", bus.fwd_a_sel_o, 32'd1);
    tick();

    // LW r5 ; flushed dependent ADD
    set_in(1, 1, 0, 5, 1, 1, 1, 0, 0); tick();
    set_in(1, 5, 5, 6, 1, 0, 0, 1, 0);
    chk("t5_flush_stall", bus.stall_o, 32'd0);
    tick();
    nop();
    chk("t5_a", bus.fwd_a_sel_o, 32'd0);
    chk("t5_b", bus.fwd_b_sel_o, 32'd0);
    tick();

    // Reset with three writers in flight
    set_in(1, 0, 0, 1, 1, 0, 0, 0, 0); tick();
    set_in(1, 0, 0, 2, 1, 0, 0, 0, 0); tick();
    set_in(1, 0, 0, 3, 1, 1, 1, 0, 0); tick();
    set_in(1, 3, 2, 9, 1, 0, 0, 0, 1);
    chk("t6_rst_stall", bus.stall_o, 32'd0);
    tick();
    set_in(1, 3, 1, 9, 1, 0, 0, 0, 0);
    chk("t6_post_stall", bus.stall_o, 32'd0);
    chk("t6_post_a", bus.fwd_a_sel_o, 32'd0);
    tick();
    nop();
    chk("t6_first_a", bus.fwd_a_sel_o, 32'd0);
    chk("t6_first_b", bus.fwd_b_sel_o, 32'd0);
    tick();

    // Random traffic; a stalled instruction is re-presented the next cycle.
    for (int i = 0; i < 600; i++) begin
      bit fl, r;
      hold = exp_stall;
      fl = ($urandom % 16) == 0;
      r  = ($urandom % 64) == 0;
      if (hold) begin
        h = cur;
        set_in(h.v, h.rs, h.rt, h.rd, h.rw, h.mr, h.as, fl, r);
      end else begin
        bit mr;
        mr = ($urandom % 4) == 0;
        set_in(($urandom % 8) != 0, int'($urandom % 8), int'($urandom % 8),
               int'($urandom % 8), mr || (($urandom % 4) != 0), mr,
               ($urandom % 4) == 0, fl, r);
      end
      tick();
    end

`ifdef FWD_HAZARD_STATS_EN
    // Continuous forwarding drives the forward counter into saturation.
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    nop();
    chk("cnt_clr_fwd", bus.fwd_cnt_o, 32'd0);
    chk("cnt_clr_stall", bus.stall_cnt_o, 32'd0);
    tick();
    for (int i = 0; i < 65540; i++) begin
      set_in(1, 3, 3, 3, 1, 0, 0, 0, 0);
      tick();
    end
    set_in(1, 3, 3, 3, 1, 0, 0, 0, 0);
    chk("fwd_sat", bus.fwd_cnt_o, 32'h0000_FFFF);
    tick();
    set_in(1, 3, 3, 3, 1, 0, 0, 0, 0);
    chk("fwd_sat_hold", bus.fwd_cnt_o, 32'h0000_FFFF);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
